fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares the single write port of the 8-entry sync FIFO among NUM_REQ producers.
- Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO write_en/data_in.
- Honours FIFO full as backpressure.
- Sits directly upstream of the FIFO write side.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 138 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Bus between NUM_REQ producers, the write arbiter and the FIFO write port.
//   req_valid/req_data/req_ready : per-requester valid/ready handshake
//   fifo_full                    : FIFO backpressure
//   fifo_write_en/fifo_data_in   : FIFO write port
// Modports: master = producers + FIFO side (testbench), slave = arbiter.
`timescale 1ns/1ps
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_write_en;
  logic [DATA_W-1:0]         fifo_data_in;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_write_en, fifo_data_in
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_write_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ
// producers. A grant lasts up to MAX_BURST accepted beats, or until the
// granted requester drops valid; one IDLE arbitration cycle sits between
// grants, and the released requester has lowest priority next time.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : fifo_wr_arbiter_if.slave (requester handshakes + FIFO write port)
//   grant  : one-hot current grant, 0 when idle
//   busy   : high while a grant is active
// Optional build macro FIFO_ARB_HIPRI_EN: requester 0 becomes high priority
// (wins every arbitration it requests, and pre-empts other grants after a beat).
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  fifo_wr_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]   r_gidx,  w_gidx_nxt;
  logic [IDX_W-1:0]   r_last,  w_last_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;

  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_rr_idx;
  logic               w_rr_any;
  logic               w_beat;
  logic               w_release;

  // State register; reset leaves the pointer on the last index so requester 0 wins first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_gidx_nxt        = r_gidx;
    w_last_nxt        = r_last;
    w_cnt_nxt         = r_cnt;
    w_cand            = '0;
    w_rr_idx          = r_last;
    w_rr_any          = 1'b0;
    w_beat            = 1'b0;
    w_release         = 1'b0;
    bus.req_ready     = '0;
    bus.fifo_write_en = 1'b0;
    bus.fifo_data_in  = bus.req_data[32'(r_gidx)*DATA_W +: DATA_W];
    grant             = r_grant;
    busy              = (r_state == ST_GRANT);

    // Circular search upward from the requester after the last round-robin winner
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(r_last) + k) % NUM_REQ);
      if (!w_rr_any && bus.req_valid[w_cand]) begin
        w_rr_any = 1'b1;
        w_rr_idx = w_cand;
      end
    end

    case (r_state)
      ST_IDLE: begin
`ifdef FIFO_ARB_HIPRI_EN
        // Priority grant to requester 0 leaves the round-robin pointer alone
        if (bus.req_valid[0]) begin
          w_state_nxt = ST_GRANT;
          w_gidx_nxt  = '0;
          w_grant_nxt = NUM_REQ'(1);
          w_cnt_nxt   = '0;
        end else
`endif
        if (w_rr_any) begin
          w_state_nxt = ST_GRANT;
          w_gidx_nxt  = w_rr_idx;
          w_last_nxt  = w_rr_idx;
          w_grant_nxt = NUM_REQ'(1) << w_rr_idx;
          w_cnt_nxt   = '0;
        end
      end

      ST_GRANT: begin
        w_beat            = bus.req_valid[r_gidx] && !bus.fifo_full;
        bus.req_ready     = bus.fifo_full ? '0 : r_grant;
        bus.fifo_write_en = w_beat;
        // Dropped valid always releases, even while the FIFO is full
        w_release = !bus.req_valid[r_gidx] ||
                    (w_beat && (r_cnt == CNT_W'(MAX_BURST - 1)));
`ifdef FIFO_ARB_HIPRI_EN
        if (w_beat && (r_gidx != '0) && bus.req_valid[0]) begin
          w_release = 1'b1;
        end
`endif
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: two instances (MAX_BURST=4 and 1) share the
// same stimulus. Directed table vectors and hand-written sequences, then
// random traffic checked every cycle against a grant-ownership model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) if0 ();
  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) if1 ();

  logic [NR-1:0] grant0, grant1;
  logic          busy0, busy1;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave), .grant(grant0), .busy(busy0));
  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .grant(grant1), .busy(busy1));

  assign if1.req_valid = if0.req_valid;
  assign if1.req_data  = if0.req_data;
  assign if1.fifo_full = if0.fifo_full;

  logic [3:0]  s_valid;
  logic        s_full;
  logic [31:0] s_data;

  int n_chk = 0;
  int n_err = 0;

  // Model: who owns the write port (-1 = nobody), beats taken, round-robin pointer
  int m_owner[2];
  int m_beats[2];
  int m_last[2];
  int m_max[2] = '{4, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_beats[k] = 0;
      m_last[k]  = NR - 1;
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] a_g, a_r, e_g, e_r;
      logic       a_b, a_w, e_b, e_w;
      logic [7:0] a_d, e_d;
      if (k == 0) begin
        a_g = grant0; a_b = busy0; a_r = if0.req_ready; a_w = if0.fifo_write_en; a_d = if0.fifo_data_in;
      end else begin
        a_g = grant1; a_b = busy1; a_r = if1.req_ready; a_w = if1.fifo_write_en; a_d = if1.fifo_data_in;
      end
      e_g = '0; e_r = '0; e_b = 1'b0; e_w = 1'b0; e_d = '0;
      if (m_owner[k] >= 0) begin
        e_g = 4'(1 << m_owner[k]);
        e_b = 1'b1;
        e_r = s_full ? 4'b0 : e_g;
        e_w = s_valid[m_owner[k]] && !s_full;
        e_d = s_data[m_owner[k]*8 +: 8];
      end
      chk($sformatf("model_grant dut%0d", k), 32'(a_g), 32'(e_g));
      chk($sformatf("model_busy dut%0d", k), 32'(a_b), 32'(e_b));
      chk($sformatf("model_ready dut%0d", k), 32'(a_r), 32'(e_r));
      chk($sformatf("model_we dut%0d", k), 32'(a_w), 32'(e_w));
      if (e_w) chk($sformatf("model_data dut%0d", k), 32'(a_d), 32'(e_d));
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (m_owner[k] < 0) begin
        int pick;
        pick = -1;
`ifdef FIFO_ARB_HIPRI_EN
        if (s_valid[0]) begin
          m_owner[k] = 0;
          m_beats[k] = 0;
        end else
`endif
        begin
          for (int j = 1; j <= NR; j++) begin
            int i;
            i = (m_last[k] + j) % NR;
            if (pick < 0 && s_valid[i]) pick = i;
          end
          if (pick >= 0) begin
            m_owner[k] = pick;
            m_last[k]  = pick;
            m_beats[k] = 0;
          end
        end
      end else begin
        bit wrote;
        bit done;
        wrote = s_valid[m_owner[k]] && !s_full;
        if (wrote) m_beats[k]++;
        done = !s_valid[m_owner[k]] || (m_beats[k] == m_max[k]);
`ifdef FIFO_ARB_HIPRI_EN
        if (wrote && m_owner[k] != 0 && s_valid[0]) done = 1'b1;
`endif
        if (done) m_owner[k] = -1;
      end
    end
  endtask

  task automatic drive_zero();
    s_valid = '0; s_full = 1'b0; s_data = '0;
    if0.req_valid = '0; if0.fifo_full = 1'b0; if0.req_data = '0;
  endtask

  // One cycle: drive at negedge, check against model, advance model for the next posedge
  task automatic tick(input logic [3:0] v, input logic f, input logic [31:0] d);
    @(negedge clk);
    s_valid = v; s_full = f; s_data = d;
    if0.req_valid = v; if0.fifo_full = f; if0.req_data = d;
    #1;
    model_check();
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_zero();
    reset = 1'b0;
    #1;
    chk("reset_grant0", 32'(grant0), 32'h0);
    chk("reset_grant1", 32'(grant1), 32'h0);
    chk("reset_we0", 32'(if0.fifo_write_en), 32'h0);
    chk("reset_busy0", 32'(busy0), 32'h0);
    chk("reset_ready0", 32'(if0.req_ready), 32'h0);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] v;
    logic       f;
    logic [7:0] d;
    logic [3:0] eg;
    logic       ew;
    logic [3:0] er;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [3:0] v, logic f, logic [7:0] d,
                              logic [3:0] eg, logic ew, logic [3:0] er);
    vec_t r;
    r.rst = rst; r.v = v; r.f = f; r.d = d; r.eg = eg; r.ew = ew; r.er = er;
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [31:0] d;

    reset = 1'b0;
    drive_zero();
    model_reset();

    // Expectations below are for the MAX_BURST=4 instance (dut0)
    // Single burst longer than MAX_BURST on requester 0
    tbl.push_back(mk(1, 4'h1, 0, 8'h10, 4'h0, 0, 4'h0));
    tbl.push_back(mk(0, 4'h1, 0, 8'h10, 4'h1, 1, 4'h1));
    tbl.push_back(mk(0, 4'h1, 0, 8'h11, 4'h1, 1, 4'h1));
    tbl.push_back(mk(0, 4'h1, 0, 8'h12, 4'h1, 1, 4'h1));
    tbl.push_back(mk(0, 4'h1, 0, 8'h13, 4'h1, 1, 4'h1));
    tbl.push_back(mk(0, 4'h1, 0, 8'h14, 4'h0, 0, 4'h0));
    tbl.push_back(mk(0, 4'h1, 0, 8'h14, 4'h1, 1, 4'h1));
    tbl.push_back(mk(0, 4'h1, 0, 8'h15, 4'h1, 1, 4'h1));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, 4'h1, 0, 4'h1));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, 4'h0, 0, 4'h0));
    // Backpressure on requester 2: three full cycles, four beats total
    tbl.push_back(mk(1, 4'h4, 0, 8'h20, 4'h0, 0, 4'h0));
    tbl.push_back(mk(0, 4'h4, 0, 8'h20, 4'h4, 1, 4'h4));
    tbl.push_back(mk(0, 4'h4, 1, 8'h21, 4'h4, 0, 4'h0));
    tbl.push_back(mk(0, 4'h4, 1, 8'h21, 4'h4, 0, 4'h0));
    tbl.push_back(mk(0, 4'h4, 1, 8'h21, 4'h4, 0, 4'h0));
    tbl.push_back(mk(0, 4'h4, 0, 8'h21, 4'h4, 1, 4'h4));
    tbl.push_back(mk(0, 4'h4, 0, 8'h22, 4'h4, 1, 4'h4));
    tbl.push_back(mk(0, 4'h4, 0, 8'h23, 4'h4, 1, 4'h4));
    tbl.push_back(mk(0, 4'h4, 0, 8'h24, 4'h0, 0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, 4'h4, 0, 4'h4));
    // Early valid drop on requester 3, then a fresh full-length burst
    tbl.push_back(mk(1, 4'h8, 0, 8'hAA, 4'h0, 0, 4'h0));
    tbl.push_back(mk(0, 4'h8, 0, 8'hAA, 4'h8, 1, 4'h8));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, 4'h8, 0, 4'h8));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, 4'h0, 0, 4'h0));
    tbl.push_back(mk(0, 4'h8, 0, 8'hB0, 4'h0, 0, 4'h0));
    tbl.push_back(mk(0, 4'h8, 0, 8'hB0, 4'h8, 1, 4'h8));
    tbl.push_back(mk(0, 4'h8, 0, 8'hB1, 4'h8, 1, 4'h8));
    tbl.push_back(mk(0, 4'h8, 0, 8'hB2, 4'h8, 1, 4'h8));
    tbl.push_back(mk(0, 4'h8, 0, 8'hB3, 4'h8, 1, 4'h8));
    tbl.push_back(mk(0, 4'h8, 0, 8'hB4, 4'h0, 0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, 4'h8, 0, 4'h8));
    // Full and valid drop together: release wins
    tbl.push_back(mk(1, 4'h2, 0, 8'h30, 4'h0, 0, 4'h0));
    tbl.push_back(mk(0, 4'h2, 1, 8'h30, 4'h2, 0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 1, 8'h00, 4'h2, 0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, 4'h0, 0, 4'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      tick(tbl[i].v, tbl[i].f, {4{tbl[i].d}});
      chk($sformatf("vec%0d_grant", i), 32'(grant0), 32'(tbl[i].eg));
      chk($sformatf("vec%0d_we", i), 32'(if0.fifo_write_en), 32'(tbl[i].ew));
      chk($sformatf("vec%0d_ready", i), 32'(if0.req_ready), 32'(tbl[i].er));
      chk($sformatf("vec%0d_busy", i), 32'(busy0), 32'(tbl[i].eg != 4'h0));
      if (tbl[i].ew) chk($sformatf("vec%0d_data", i), 32'(if0.fifo_data_in), 32'(tbl[i].d));
    end

    // Round-robin fairness on the MAX_BURST=1 instance: 0,1,2,3,0,1 with idle gaps
    do_reset();
    for (int c = 0; c < 12; c++) begin
      d = $urandom;
      tick(4'hF, 1'b0, d);
      if (c % 2 == 0) begin
        chk($sformatf("rr%0d_grant", c), 32'(grant1), 32'h0);
        chk($sformatf("rr%0d_we", c), 32'(if1.fifo_write_en), 32'h0);
      end else begin
        chk($sformatf("rr%0d_grant", c), 32'(grant1), 32'(1 << (((c - 1) / 2) % 4)));
        chk($sformatf("rr%0d_we", c), 32'(if1.fifo_write_en), 32'h1);
        chk($sformatf("rr%0d_data", c), 32'(if1.fifo_data_in), 32'(d[((c - 1) / 2 % 4)*8 +: 8]));
      end
    end

    // Asynchronous reset in the middle of a burst from requester 1
    do_reset();
    tick(4'h2, 1'b0, 32'h41414141);
    tick(4'h2, 1'b0, 32'h42424242);
    tick(4'h2, 1'b0, 32'h43434343);
    tick(4'h2, 1'b0, 32'h44444444);
    chk("midrst_pre_grant", 32'(grant0), 32'h2);
    chk("midrst_pre_we", 32'(if0.fifo_write_en), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant0), 32'h0);
    chk("midrst_we", 32'(if0.fifo_write_en), 32'h0);
    chk("midrst_busy", 32'(busy0), 32'h0);
    reset = 1'b1;
    drive_zero();
    model_reset();
    tick(4'hF, 1'b0, 32'h0);
    tick(4'hF, 1'b0, 32'h0);
    chk("postrst_grant0", 32'(grant0), 32'h1);
    chk("postrst_grant1", 32'(grant1), 32'h1);

`ifdef FIFO_ARB_HIPRI_EN
    // Requester 0 pre-empts requester 2 after its second beat
    do_reset();
    tick(4'h4, 1'b0, 32'h0);
    chk("hp_idle", 32'(grant0), 32'h0);
    tick(4'h4, 1'b0, 32'h0);
    chk("hp_beat1", 32'(if0.fifo_write_en), 32'h1);
    tick(4'h5, 1'b0, 32'h0);
    chk("hp_beat2_grant", 32'(grant0), 32'h4);
    chk("hp_beat2_we", 32'(if0.fifo_write_en), 32'h1);
    tick(4'h5, 1'b0, 32'h0);
    chk("hp_gap", 32'(grant0), 32'h0);
    tick(4'h5, 1'b0, 32'h0);
    chk("hp_grant0", 32'(grant0), 32'h1);
    tick(4'hC, 1'b0, 32'h0);
    tick(4'hC, 1'b0, 32'h0);
    chk("hp_gap2", 32'(grant0), 32'h0);
    tick(4'hC, 1'b0, 32'h0);
    chk("hp_next_rr", 32'(grant0), 32'h8);
`endif

    // Random traffic against the model, with occasional asynchronous resets
    do_reset();
    s_valid = '0;
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] v;
      v = s_valid ^ 4'($urandom & $urandom);
      tick(v, ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
